// File: rtl/game_timer_screen.sv
// BCD stopwatch with best-time register, drawing both times as 4x7 segment digits on a 96x64 OLED.
// Define NEW_BEST_BLINK_EN to blink the best field after a new record; otherwise it stays steady.
module game_timer_screen #(
  parameter int unsigned TICK_DIV  = 6250000,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned TT_X0     = 54,
  parameter int unsigned TT_Y0     = 25,
  parameter int unsigned BT_X0     = 54,
  parameter int unsigned BT_Y0     = 47,
  parameter logic [15:0] FG_COLOUR = 16'h07E0,
  parameter logic [15:0] BG_COLOUR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [6:0]            x,
  input  logic [5:0]            y,
  output logic [15:0]           oled_data,
  output logic                  pixel_on,
  output logic [4*DIGITS-1:0]   time_bcd,
  output logic [4*DIGITS-1:0]   best_bcd,
  output logic                  best_valid,
  output logic                  new_best,
  output logic                  running
);
  localparam int unsigned   TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam int unsigned   BW       = 4 * DIGITS;
  localparam logic [BW-1:0] ALL9     = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, SHOW} state_t;
  state_t r_state, w_state_nxt;

  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_live, r_time, r_best, w_live_inc, w_tt_val;
  logic          r_best_valid, r_new_best, r_pix;
  logic [15:0]   r_oled;
  logic          w_clear, w_latch, w_tick, w_better, w_best_vis, w_pix;

  // Segment mask {a,b,c,d,e,f,g}; non-decimal codes render blank.
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    seg_mask = 7'b1111110;
      4'd1:    seg_mask = 7'b0110000;
      4'd2:    seg_mask = 7'b1101101;
      4'd3:    seg_mask = 7'b1111001;
      4'd4:    seg_mask = 7'b0110011;
      4'd5:    seg_mask = 7'b1011011;
      4'd6:    seg_mask = 7'b1011111;
      4'd7:    seg_mask = 7'b1110000;
      4'd8:    seg_mask = 7'b1111111;
      4'd9:    seg_mask = 7'b1111011;
      default: seg_mask = 7'b0000000;
    endcase
  endfunction

  function automatic logic seg_pixel(input logic [6:0] m, input int unsigned c, input int unsigned r);
    return (m[6] && r == 0) || (m[5] && c == 3 && r <= 3) || (m[4] && c == 3 && r >= 3) ||
           (m[3] && r == 6) || (m[2] && c == 0 && r >= 3) || (m[1] && c == 0 && r <= 3) ||
           (m[0] && r == 3);
  endfunction

  function automatic logic field_on(input logic [BW-1:0] val, input int unsigned x0,
                                    input int unsigned y0, input int unsigned px,
                                    input int unsigned py);
    logic        hit;
    int unsigned cx;
    hit = 1'b0;
    if (py >= y0 && py < y0 + 7) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        cx = x0 + 6 * i;
        if (px >= cx && px < cx + 4)
          hit = hit | seg_pixel(seg_mask(4'(val >> (4 * (DIGITS - 1 - i)))), px - cx, py - y0);
      end
    end
    return hit;
  endfunction

  // Stop has priority over start in RUN; in SHOW a simultaneous stop is simply ignored.
  assign w_latch  = (r_state == RUN) && stop;
  assign w_clear  = start && !w_latch;
  assign w_tick   = (r_state == RUN) && (r_tick == TICK_MAX);
  assign w_better = !r_best_valid || (r_live < r_best);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (stop) w_state_nxt = SHOW;
      SHOW:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    logic       carry;
    logic [3:0] dig;
    w_live_inc = r_live;
    carry      = 1'b1;
    dig        = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = 4'(r_live >> (4 * i));
      if (carry) begin
        if (dig == 4'd9) dig = 4'd0;
        else begin
          dig   = dig + 4'd1;
          carry = 1'b0;
        end
        w_live_inc = (w_live_inc & ~(BW'(4'hF) << (4 * i))) | (BW'(dig) << (4 * i));
      end
    end
    if (r_live == ALL9) w_live_inc = r_live;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick       <= '0;
      r_live       <= '0;
      r_time       <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_new_best   <= 1'b0;
    end else begin
      if (w_clear) begin
        r_tick <= '0;
        r_live <= '0;
      end else if (r_state == RUN && !stop) begin
        r_tick <= w_tick ? '0 : r_tick + 1'b1;
        if (w_tick) r_live <= w_live_inc;
      end
      if (w_latch) begin
        r_time <= r_live;
        if (w_better) begin
          r_best       <= r_live;
          r_best_valid <= 1'b1;
          r_new_best   <= 1'b1;
        end else begin
          r_new_best   <= 1'b0;
        end
      end
    end
  end

`ifdef NEW_BEST_BLINK_EN
  logic [TW-1:0] r_bdiv;
  logic [1:0]    r_bphase;

  // Phase counts ticks since the last stop; bit 1 set means the blank half of the blink.
  always_ff @(posedge clk) begin
    if (reset || w_latch) begin
      r_bdiv   <= '0;
      r_bphase <= '0;
    end else if (r_bdiv == TICK_MAX) begin
      r_bdiv   <= '0;
      r_bphase <= r_bphase + 2'd1;
    end else begin
      r_bdiv   <= r_bdiv + 1'b1;
    end
  end

  assign w_best_vis = r_best_valid && !(r_new_best && (r_state != RUN) && r_bphase[1]);
`else
  assign w_best_vis = r_best_valid;
`endif

  assign w_tt_val = (r_state == RUN) ? r_live : r_time;
  assign w_pix    = field_on(w_tt_val, TT_X0, TT_Y0, 32'(x), 32'(y)) ||
                    (w_best_vis && field_on(r_best, BT_X0, BT_Y0, 32'(x), 32'(y)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oled <= BG_COLOUR;
      r_pix  <= 1'b0;
    end else begin
      r_oled <= w_pix ? FG_COLOUR : BG_COLOUR;
      r_pix  <= w_pix;
    end
  end

  assign oled_data  = r_oled;
  assign pixel_on   = r_pix;
  assign time_bcd   = r_time;
  assign best_bcd   = r_best;
  assign best_valid = r_best_valid;
  assign new_best   = r_new_best;
  assign running    = (r_state == RUN);
endmodule
